// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the I/D block-RAM arbiter.
// Response tracking uses one small state machine per port.
package bram_arb_pkg;

  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } resp_state_t;

  // A grant can only land while the slot is free or being drained this cycle.
  function automatic resp_state_t next_resp(resp_state_t cur, logic resp_ready,
                                            logic grant);
    resp_state_t nxt;
    nxt = cur;
    case (cur)
      EMPTY:   if (grant) nxt = FRESH;
      FRESH:   nxt = resp_ready ? (grant ? FRESH : EMPTY) : HELD;
      HELD:    if (resp_ready) nxt = grant ? FRESH : EMPTY;
      default: nxt = EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bram_arbiter_single_bram.sv
// Single-port, read-first block RAM with per-byte write enables.
// data_r only updates on an enabled access and holds otherwise.
module single_bram #(
  parameter int ADDR_W = 14,
  parameter int SIZE   = 1 << ADDR_W,
  parameter int DATA_L = 4
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_L-1:0]     sel,
  input  logic [DATA_L*8-1:0]   wdata,
  output logic [DATA_L*8-1:0]   data_r
);

  logic [DATA_L*8-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (en) begin
      data_r <= mem[addr];
      if (we) begin
        for (int b = 0; b < DATA_L; b++) begin
          if (sel[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin sharing of one block RAM between the instruction-fetch and data ports,
// with a per-port response slot that parks unread data in a hold register.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int SIZE   = 1 << ADDR_W,
  parameter int DATA_L = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_W-1:0]     i_req_addr,
  output logic                  i_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_L*8-1:0]   i_resp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic                  d_req_we,
  input  logic [DATA_L-1:0]     d_req_sel,
  input  logic [DATA_L*8-1:0]   d_req_wdata,
  output logic                  d_resp_valid,
  input  logic                  d_resp_ready,
  output logic [DATA_L*8-1:0]   d_resp_data
);

  localparam int DATA_W = DATA_L * 8;

  resp_state_t         i_state_q, i_state_d, d_state_q, d_state_d;
  port_t               prio_q;
  logic [DATA_W-1:0]   i_hold_q, d_hold_q, bram_rdata;
  logic                elig_i, elig_d, grant_i, grant_d;
  logic                bram_en, bram_we;
  logic [ADDR_W-1:0]   bram_addr;

  // A port may only issue when its single response slot is free or draining now.
  always_comb begin
    elig_i  = 1'b0;
    elig_d  = 1'b0;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      elig_i = i_req_valid && (i_state_q == EMPTY || i_resp_ready);
      elig_d = d_req_valid && (d_state_q == EMPTY || d_resp_ready);
    end
    grant_i = elig_i && (!elig_d || prio_q == PORT_I);
    grant_d = elig_d && (!elig_i || prio_q == PORT_D);
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  assign bram_en   = grant_i | grant_d;
  assign bram_we   = grant_d & d_req_we;
  assign bram_addr = grant_d ? d_req_addr : i_req_addr;

  single_bram #(
    .ADDR_W (ADDR_W),
    .SIZE   (SIZE),
    .DATA_L (DATA_L)
  ) u_bram (
    .clk    (clk),
    .en     (bram_en),
    .we     (bram_we),
    .addr   (bram_addr),
    .sel    (d_req_sel),
    .wdata  (d_req_wdata),
    .data_r (bram_rdata)
  );

  always_comb begin
    i_state_d = next_resp(i_state_q, i_resp_ready, grant_i);
    d_state_d = next_resp(d_state_q, d_resp_ready, grant_d);
  end

  // FRESH lasts one cycle: a stalled consumer is moved to the hold register before
  // the other port's access can overwrite data_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_state_q <= EMPTY;
      d_state_q <= EMPTY;
      prio_q    <= PORT_I;
      i_hold_q  <= '0;
      d_hold_q  <= '0;
    end else begin
      i_state_q <= i_state_d;
      d_state_q <= d_state_d;
      if (grant_i)      prio_q <= PORT_D;
      else if (grant_d) prio_q <= PORT_I;
      if (i_state_q == FRESH && !i_resp_ready) i_hold_q <= bram_rdata;
      if (d_state_q == FRESH && !d_resp_ready) d_hold_q <= bram_rdata;
    end
  end

  assign i_resp_valid = (i_state_q != EMPTY);
  assign d_resp_valid = (d_state_q != EMPTY);
  assign i_resp_data  = (i_state_q == HELD) ? i_hold_q : bram_rdata;
  assign d_resp_data  = (d_state_q == HELD) ? d_hold_q : bram_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios plus random traffic, checked by a
// reference memory model feeding per-port expected-response queues.
module tb_bram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_L = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_resp_data;
  logic              d_req_valid, d_req_ready, d_req_we, d_resp_valid, d_resp_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_L-1:0] d_req_sel;
  logic [DATA_W-1:0] d_req_wdata, d_resp_data;

  bram_arbiter #(.ADDR_W(ADDR_W), .DATA_L(DATA_L)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .i_req_ready  (i_req_ready),
    .i_req_addr   (i_req_addr),
    .i_resp_valid (i_resp_valid),
    .i_resp_ready (i_resp_ready),
    .i_resp_data  (i_resp_data),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_addr   (d_req_addr),
    .d_req_we     (d_req_we),
    .d_req_sel    (d_req_sel),
    .d_req_wdata  (d_req_wdata),
    .d_resp_valid (d_resp_valid),
    .d_resp_ready (d_resp_ready),
    .d_resp_data  (d_resp_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] i_exp_q[$];
  logic [DATA_W-1:0] d_exp_q[$];
  logic [DATA_W-1:0] mem_model [int];
  logic              grant_log[$];
  logic              i_lat_chk = 1'b0;
  logic              d_lat_chk = 1'b0;

  function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
    return mem_model.exists(int'(a)) ? mem_model[int'(a)] : '0;
  endfunction

  always @(negedge clk) begin
    logic [DATA_W-1:0] w;
    if (rst) begin
      i_exp_q.delete();
      d_exp_q.delete();
      grant_log.delete();
      i_lat_chk = 1'b0;
      d_lat_chk = 1'b0;
    end else begin
      if (i_lat_chk) check("i_latency", 32'(i_resp_valid), 32'd1);
      if (d_lat_chk) check("d_latency", 32'(d_resp_valid), 32'd1);
      i_lat_chk = 1'b0;
      d_lat_chk = 1'b0;
      check("one_grant", 32'(i_req_ready & d_req_ready), 32'd0);
      if (i_resp_valid && i_resp_ready) begin
        check("i_expected", 32'(i_exp_q.size() != 0), 32'd1);
        if (i_exp_q.size() != 0) check("i_data", i_resp_data, i_exp_q.pop_front());
      end
      if (d_resp_valid && d_resp_ready) begin
        check("d_expected", 32'(d_exp_q.size() != 0), 32'd1);
        if (d_exp_q.size() != 0) check("d_data", d_resp_data, d_exp_q.pop_front());
      end
      if (i_req_valid && i_req_ready) begin
        i_exp_q.push_back(model_rd(i_req_addr));
        grant_log.push_back(1'b0);
        i_lat_chk = 1'b1;
      end
      if (d_req_valid && d_req_ready) begin
        w = model_rd(d_req_addr);
        d_exp_q.push_back(w);
        if (d_req_we) begin
          for (int b = 0; b < DATA_L; b++)
            if (d_req_sel[b]) w[b*8 +: 8] = d_req_wdata[b*8 +: 8];
          mem_model[int'(d_req_addr)] = w;
        end
        grant_log.push_back(1'b1);
        d_lat_chk = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic d_xfer(input logic [ADDR_W-1:0] a, input logic we,
                        input logic [DATA_L-1:0] sel, input logic [DATA_W-1:0] wd,
                        output logic [DATA_W-1:0] rd);
    logic ok;
    ok = 1'b0;
    d_req_valid = 1'b1; d_req_addr = a; d_req_we = we; d_req_sel = sel; d_req_wdata = wd;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = d_req_ready;
      tick();
    end
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    check("d_accept", 32'(ok), 32'd1);
    rd = d_resp_data;
  endtask

  task automatic i_xfer(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] rd);
    logic ok;
    ok = 1'b0;
    i_req_valid = 1'b1; i_req_addr = a;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = i_req_ready;
      tick();
    end
    i_req_valid = 1'b0;
    check("i_accept", 32'(ok), 32'd1);
    rd = i_resp_data;
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: time limit reached");
    finish_run();
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] r;
    rst = 1'b1;
    i_req_valid = 0; i_req_addr = '0; i_resp_ready = 1'b1;
    d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_sel = '0; d_req_wdata = '0;
    d_resp_ready = 1'b1;
    tick();
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    @(negedge clk);
    check("rst_i_resp_valid", 32'(i_resp_valid), 32'd0);
    check("rst_d_resp_valid", 32'(d_resp_valid), 32'd0);
    check("rst_i_req_ready",  32'(i_req_ready),  32'd0);
    check("rst_d_req_ready",  32'(d_req_ready),  32'd0);
    tick();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    rst = 1'b0;

    for (int a = 0; a < 32; a++) d_xfer(ADDR_W'(a), 1'b1, 4'hF, $urandom, r);

    // 1: write then read back through the I port
    d_xfer(14'd5, 1'b1, 4'hF, 32'hDEADBEEF, r);
    i_xfer(14'd5, r);
    check("t1_i_read", r, 32'hDEADBEEF);

    // 2: both ports streaming; grants alternate starting with I after reset
    do_reset();
    i_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b0;
    for (int k = 0; k < 12; k++) begin
      i_req_addr = ADDR_W'($urandom_range(0, 31));
      d_req_addr = ADDR_W'($urandom_range(0, 31));
      tick();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    check("t2_grants", 32'(grant_log.size()), 32'd12);
    for (int k = 0; k < 12 && k < grant_log.size(); k++)
      check("t2_order", 32'(grant_log[k]), 32'(k % 2));
    tick();

    // 3: partial byte write returns the old word, later read shows the merge
    d_xfer(14'd5, 1'b1, 4'b0101, 32'h11223344, r);
    check("t3_wr_resp", r, 32'hDEADBEEF);
    i_xfer(14'd5, r);
    check("t3_merged", r, 32'hDE22BE44);

    // 4: stalled I consumer, D keeps streaming
    d_xfer(14'd9, 1'b1, 4'hF, 32'hCAFEF00D, r);
    i_resp_ready = 1'b0;
    i_xfer(14'd9, r);
    check("t4_fresh", r, 32'hCAFEF00D);
    i_req_valid = 1'b1; i_req_addr = 14'd3;
    d_req_valid = 1'b1; d_req_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d_req_addr = ADDR_W'($urandom_range(0, 31));
      @(negedge clk);
      check("t4_held_data",  i_resp_data, 32'hCAFEF00D);
      check("t4_held_valid", 32'(i_resp_valid), 32'd1);
      check("t4_i_blocked",  32'(i_req_ready), 32'd0);
      check("t4_d_granted",  32'(d_req_ready), 32'd1);
      tick();
    end
    i_resp_ready = 1'b1; d_req_valid = 1'b0;
    @(negedge clk);
    check("t4_i_resume", 32'(i_req_ready), 32'd1);
    tick();
    i_req_valid = 1'b0;
    tick();

    // 5: reset right after a D read grant drops the response
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 14'd5;
    @(negedge clk);
    check("t5_d_grant", 32'(d_req_ready), 32'd1);
    tick();
    check("t5_pre_rst_valid", 32'(d_resp_valid), 32'd1);
    i_req_valid = 1'b1; i_req_addr = 14'd7;
    rst = 1'b1;
    #1;
    check("t5_rst_drop", 32'(d_resp_valid), 32'd0);
    @(negedge clk);
    check("t5_rst_i_ready", 32'(i_req_ready), 32'd0);
    check("t5_rst_d_ready", 32'(d_req_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_first_i",   32'(i_req_ready), 32'd1);
    check("t5_not_d",     32'(d_req_ready), 32'd0);
    check("t5_no_d_resp", 32'(d_resp_valid), 32'd0);
    tick();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();
    tick();

    // 6: write with no byte enables is acknowledged but leaves memory alone
    d_xfer(14'd7, 1'b1, 4'hF, 32'h0000ABCD, r);
    d_xfer(14'd7, 1'b1, 4'h0, 32'hFFFFFFFF, r);
    check("t6_ack_data", r, 32'h0000ABCD);
    d_xfer(14'd7, 1'b0, 4'h0, 32'h0, r);
    check("t6_unchanged", r, 32'h0000ABCD);

    // random mixed traffic with back-pressure
    for (int k = 0; k < 300; k++) begin
      i_req_valid  = 1'($urandom_range(0, 1));
      i_req_addr   = ADDR_W'($urandom_range(0, 31));
      i_resp_ready = ($urandom_range(0, 3) != 0);
      d_req_valid  = 1'($urandom_range(0, 1));
      d_req_addr   = ADDR_W'($urandom_range(0, 31));
      d_req_we     = 1'($urandom_range(0, 1));
      d_req_sel    = DATA_L'($urandom_range(0, 15));
      d_req_wdata  = $urandom;
      d_resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    i_resp_ready = 1'b1; d_resp_ready = 1'b1;
    repeat (4) tick();
    check("drain_i", 32'(i_exp_q.size()), 32'd0);
    check("drain_d", 32'(d_exp_q.size()), 32'd0);

    finish_run();
  end

endmodule
